interrupt_priority_arbiter: RTL and testbench
=============================================

Name: interrupt_priority_arbiter

Overview:
Priority resolver and acknowledge sequencer for the 8259A-compatible interrupt controller. It latches the eight IR request lines into IRR and picks the winning request against IMR and ISR under fully nested or rotating priority. It raises INT, runs the two-pulse INTA acknowledge, and maintains ISR under EOI commands. It feeds the vector and EOI logic of ControlLogic.

Parameters:
NUM_IR, 8, number of request lines (fixed at 8; sizes the 3-bit level encoding)
SPURIOUS_LEVEL, 7, level reported when INTA arrives with no valid candidate

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
ICW1_RECEIVED  input  1  one-cycle strobe; same effect as RESET on this block
IR  input  8  raw interrupt request lines, synchronous to CLK
IMR  input  8  interrupt mask; 1 masks that line
LEVEL_MODE  input  1  1 = level-triggered (ICW1 LTIM), 0 = edge-triggered
AUTO_EOI  input  1  ICW4 AEOI
ROTATE_ON_AEOI  input  1  rotate priority on automatic EOI
INTA  input  1  one-cycle strobe per INTA pulse from CPU interface
NS_EOI  input  1  strobe: non-specific EOI
SP_EOI  input  1  strobe: specific EOI at EOI_LEVEL
ROTATE  input  1  qualifies NS_EOI/SP_EOI: rotate priority to the cleared level
SET_PRIORITY  input  1  strobe: lowest-priority pointer := EOI_LEVEL
EOI_LEVEL  input  3  level for SP_EOI and SET_PRIORITY
INT  output  1  interrupt request to CPU, registered
IRR  output  8  interrupt request register
ISR  output  8  in-service register
VECTOR_LEVEL  output  3  acknowledged level, held until next acknowledge
VECTOR_VALID  output  1  one-cycle pulse on the second INTA

Behaviour:
- Reset (RESET or ICW1_RECEIVED):
  - IRR=0, ISR=0, INT=0, VECTOR_LEVEL=0, VECTOR_VALID=0.
  - Lowest-priority pointer LP=7, so IR0 is highest priority.
  - FSM=IDLE; edge-history register=8'hFF.
  - A line held high across reset must go low, then high, before it is latched.
- Request capture, every cycle:
  - Edge mode: IRR[i] sets when IR[i]=1 and hist[i]=0. hist<=IR every cycle.
  - Level mode: IRR[i]<=IR[i].
  - Both modes: IRR[i] clears on the first-INTA cycle that acknowledges level i; that clear takes precedence over a set in the same cycle.
- Priority order: LP+1, LP+2, ..., LP (mod 8); wrap-around is modulo 8.
  - Candidate = highest-priority set bit of IRR & ~IMR.
  - Current = highest-priority set bit of ISR.
- INT:
  - Registered. INT<=1 when a candidate exists and either ISR=0 or the candidate outranks current (fully nested).
  - INT is forced to 0 in the cycle after the first INTA and stays 0 until FSM returns to IDLE.
  - Latency: IR edge -> IRR set at cycle+1 -> INT at cycle+2.
- FSM: IDLE, ACK1, ACK2.
  - IDLE + INTA -> ACK1. Winner level W is frozen from the current candidate.
    - If a candidate exists: ISR[W]<=1, IRR[W]<=0.
    - If no candidate (spurious): W=SPURIOUS_LEVEL; ISR and IRR are unchanged.
  - ACK1 + INTA -> ACK2, with VECTOR_LEVEL<=W and VECTOR_VALID<=1 for one cycle.
    - If AUTO_EOI and not spurious: ISR[W]<=0.
    - If ROTATE_ON_AEOI is also set: LP<=W.
  - ACK2 -> IDLE unconditionally on the next cycle.
  - INTA in ACK2 is ignored.
- EOI handling (any FSM state):
  - NS_EOI clears the highest-priority ISR bit; SP_EOI clears ISR[EOI_LEVEL].
  - With ROTATE, LP<=cleared level. If NS_EOI finds ISR=0, nothing changes.
  - SET_PRIORITY: LP<=EOI_LEVEL.
  - NS_EOI and SP_EOI in the same cycle: SP_EOI wins.
  - SET_PRIORITY together with a rotating EOI: SET_PRIORITY wins.
- Simultaneous first INTA and EOI:
  - EOI is resolved against pre-update ISR; both updates apply.
  - If both target the same bit, the INTA set wins.
- IMR changes take effect in candidate selection the same cycle; a masked bit stays in IRR.

Test Plan:
- Reset with IR=8'h01 held high -> IRR stays 0, INT=0. Then IR=0 for one cycle, then 8'h01 -> IRR=8'h01 at +1, INT=1 at +2.
- IR=8'h24 (edges on IR2, IR5), LP=7, IMR=0, INTA, INTA -> ISR=8'h04, IRR=8'h20, VECTOR_LEVEL=2 with VECTOR_VALID pulse. INT re-asserts only after NS_EOI clears ISR.
- Fully nested: ISR=8'h08 (IR3 in service), request IR5 -> INT stays 0. Then request IR1 -> INT=1, and after INTA/INTA ISR=8'h0A.
- Rotation: NS_EOI+ROTATE with ISR=8'h10 -> ISR=0, LP=4. IR=8'h21 simultaneous -> IR5 wins, VECTOR_LEVEL=5.
- Spurious: IR pulse latched, then IMR=8'hFF before INTA -> INTA/INTA gives VECTOR_LEVEL=7, ISR unchanged at 0.
- AUTO_EOI=1, ROTATE_ON_AEOI=1, acknowledge IR6 -> ISR=0 after second INTA, LP=6. RESET asserted mid-ACK1 -> FSM IDLE, ISR=0, LP=7 next cycle.

Source files
------------

// File: rtl/interrupt_priority_arbiter_if.sv
// ---------------------------------------------------------------------------
// interrupt_priority_arbiter_if
//
// Bundles the request, mask, mode, acknowledge and EOI signals that run
// between the 8259A control logic and the priority arbiter. Clock and reset
// are not part of the bundle; they stay plain ports on the arbiter.
//
// Signal summary:
//   ICW1_RECEIVED  ctrl -> arb  one-cycle strobe, reinitialises the arbiter
//   IR[7:0]        ctrl -> arb  raw request lines, synchronous to CLK
//   IMR[7:0]       ctrl -> arb  interrupt mask (1 = masked)
//   LEVEL_MODE     ctrl -> arb  1 = level-triggered, 0 = edge-triggered
//   AUTO_EOI       ctrl -> arb  clear ISR automatically on the second INTA
//   ROTATE_ON_AEOI ctrl -> arb  rotate priority on an automatic EOI
//   INTA           ctrl -> arb  one-cycle strobe per INTA pulse
//   NS_EOI         ctrl -> arb  non-specific EOI strobe
//   SP_EOI         ctrl -> arb  specific EOI strobe at EOI_LEVEL
//   ROTATE         ctrl -> arb  qualifies NS_EOI/SP_EOI with a rotation
//   SET_PRIORITY   ctrl -> arb  strobe: lowest-priority level := EOI_LEVEL
//   EOI_LEVEL[2:0] ctrl -> arb  level for SP_EOI and SET_PRIORITY
//   INT            arb -> ctrl  registered interrupt request to the CPU
//   IRR[7:0]       arb -> ctrl  interrupt request register
//   ISR[7:0]       arb -> ctrl  in-service register
//   VECTOR_LEVEL   arb -> ctrl  acknowledged level, held between acks
//   VECTOR_VALID   arb -> ctrl  one-cycle pulse on the second INTA
//
// Modports: master = control logic side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface interrupt_priority_arbiter_if;
  logic       ICW1_RECEIVED;
  logic [7:0] IR;
  logic [7:0] IMR;
  logic       LEVEL_MODE;
  logic       AUTO_EOI;
  logic       ROTATE_ON_AEOI;
  logic       INTA;
  logic       NS_EOI;
  logic       SP_EOI;
  logic       ROTATE;
  logic       SET_PRIORITY;
  logic [2:0] EOI_LEVEL;
  logic       INT;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [2:0] VECTOR_LEVEL;
  logic       VECTOR_VALID;

  modport master (
    output ICW1_RECEIVED, IR, IMR, LEVEL_MODE, AUTO_EOI, ROTATE_ON_AEOI,
           INTA, NS_EOI, SP_EOI, ROTATE, SET_PRIORITY, EOI_LEVEL,
    input  INT, IRR, ISR, VECTOR_LEVEL, VECTOR_VALID
  );

  modport slave (
    input  ICW1_RECEIVED, IR, IMR, LEVEL_MODE, AUTO_EOI, ROTATE_ON_AEOI,
           INTA, NS_EOI, SP_EOI, ROTATE, SET_PRIORITY, EOI_LEVEL,
    output INT, IRR, ISR, VECTOR_LEVEL, VECTOR_VALID
  );
endinterface

// File: rtl/interrupt_priority_arbiter.sv
// ---------------------------------------------------------------------------
// interrupt_priority_arbiter
//
// Priority resolver and acknowledge sequencer of the 8259A-compatible
// interrupt controller. Latches the IR lines into IRR (edge or level mode),
// selects the winning unmasked request under fully nested or rotating
// priority, raises INT, walks the two-pulse INTA acknowledge and keeps ISR
// up to date under specific, non-specific and automatic EOI.
//
// Ports:
//   CLK    system clock
//   RESET  synchronous active-high reset
//   bus    interrupt_priority_arbiter_if.slave (requests, mask, modes,
//          acknowledge/EOI strobes in; INT, IRR, ISR, vector out)
//
// Parameters:
//   NUM_IR          number of request lines, fixed at 8 (3-bit level codes)
//   SPURIOUS_LEVEL  level reported when INTA finds no valid candidate
// ---------------------------------------------------------------------------
module interrupt_priority_arbiter #(
  parameter int NUM_IR         = 8,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic                         CLK,
  input  logic                         RESET,
  interrupt_priority_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK1 = 2'd1;
  localparam logic [1:0] ST_ACK2 = 2'd2;

  localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LEVEL);

  // Registered state
  logic [NUM_IR-1:0] irr_q,  irr_d;
  logic [NUM_IR-1:0] isr_q,  isr_d;
  logic [NUM_IR-1:0] hist_q, hist_d;
  logic              int_q,  int_d;
  logic [2:0]        vector_level_q, vector_level_d;
  logic              vector_valid_q, vector_valid_d;
  logic [2:0]        lp_q,   lp_d;
  logic [1:0]        state_q, state_d;
  logic [2:0]        win_q,  win_d;
  logic              spurious_q, spurious_d;

  // Priority resolution results
  logic              cand_found;
  logic [2:0]        cand_level;
  logic              cur_found;
  logic [2:0]        cur_level;
  logic [2:0]        cand_rank;
  logic [2:0]        cur_rank;
  logic              cand_outranks;

  // Acknowledge phase decodes
  logic              first_ack;
  logic              second_ack;

  // EOI resolution
  logic              eoi_hit;
  logic [2:0]        eoi_lvl;

  // Returns {found, level} of the highest-priority set bit of vec, where the
  // order starts at lp+1 and wraps modulo 8. Scanning from the lowest
  // priority upward lets the last hit be the winner.
  function automatic logic [3:0] pick_highest(input logic [NUM_IR-1:0] vec,
                                              input logic [2:0]        lp);
    logic [3:0] result;
    logic [2:0] lvl;
    result = 4'b0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      lvl = lp + 3'd1 + 3'(k);
      if (vec[lvl]) begin
        result = {1'b1, lvl};
      end
    end
    return result;
  endfunction

  assign {cand_found, cand_level} = pick_highest(irr_q & ~bus.IMR, lp_q);
  assign {cur_found,  cur_level}  = pick_highest(isr_q, lp_q);

  // Rank 0 is the highest priority (lp+1). The 3-bit subtraction wraps
  // naturally, giving the distance from the top of the rotating order.
  assign cand_rank     = cand_level - lp_q - 3'd1;
  assign cur_rank      = cur_level  - lp_q - 3'd1;
  assign cand_outranks = (cand_rank < cur_rank);

  assign first_ack  = (state_q == ST_IDLE) && bus.INTA;
  assign second_ack = (state_q == ST_ACK1) && bus.INTA;

  // EOI target: a specific EOI always names its level; a non-specific EOI
  // takes the highest-priority in-service level and does nothing if ISR is
  // empty. Resolution uses the ISR value before this cycle's updates.
  always_comb begin
    eoi_hit = 1'b0;
    eoi_lvl = cur_level;
    if (bus.SP_EOI) begin
      eoi_hit = 1'b1;
      eoi_lvl = bus.EOI_LEVEL;
    end else if (bus.NS_EOI && cur_found) begin
      eoi_hit = 1'b1;
      eoi_lvl = cur_level;
    end
  end

  // Request capture. Edge mode sets on a 0->1 transition against the history
  // register; level mode simply follows the lines. The history register
  // resets to all ones so a line held high through reset must drop and rise
  // again before it is seen.
  always_comb begin
    hist_d = bus.IR;
    if (bus.LEVEL_MODE) begin
      irr_d = bus.IR;
    end else begin
      irr_d = irr_q | (bus.IR & ~hist_q);
    end
    // The first-INTA clear of the winning level overrides any new set.
    if (first_ack && cand_found) begin
      irr_d[cand_level] = 1'b0;
    end
  end

  // ISR and priority pointer. Order of writes matters:
  //  - automatic EOI on the second INTA (optionally rotating),
  //  - explicit EOI clear and its optional rotation,
  //  - SET_PRIORITY overrides any rotation in the same cycle,
  //  - the first-INTA set is applied last so it wins over an EOI clear of
  //    the same bit.
  always_comb begin
    isr_d = isr_q;
    lp_d  = lp_q;

    if (second_ack && bus.AUTO_EOI && !spurious_q) begin
      isr_d[win_q] = 1'b0;
      if (bus.ROTATE_ON_AEOI) begin
        lp_d = win_q;
      end
    end

    if (eoi_hit) begin
      isr_d[eoi_lvl] = 1'b0;
      if (bus.ROTATE) begin
        lp_d = eoi_lvl;
      end
    end

    if (bus.SET_PRIORITY) begin
      lp_d = bus.EOI_LEVEL;
    end

    if (first_ack && cand_found) begin
      isr_d[cand_level] = 1'b1;
    end
  end

  // Acknowledge sequencer. The winner is frozen on the first INTA; a missing
  // candidate at that moment makes the whole acknowledge spurious, which
  // reports SPURIOUS_LEVEL and leaves ISR alone. The vector is published on
  // the second INTA and held until the next acknowledge.
  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    spurious_d     = spurious_q;
    vector_level_d = vector_level_q;
    vector_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.INTA) begin
          state_d = ST_ACK1;
          if (cand_found) begin
            win_d      = cand_level;
            spurious_d = 1'b0;
          end else begin
            win_d      = SPUR_LVL;
            spurious_d = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (bus.INTA) begin
          state_d        = ST_ACK2;
          vector_level_d = win_q;
          vector_valid_d = 1'b1;
        end
      end
      ST_ACK2: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // INT follows fully nested rules: a candidate interrupts when nothing is
  // in service or when it outranks the current in-service level. It is held
  // low from the cycle after the first INTA until the sequencer is back in
  // IDLE, so the CPU never sees a second request mid-acknowledge.
  always_comb begin
    int_d = 1'b0;
    if ((state_q == ST_IDLE) && !bus.INTA && cand_found) begin
      int_d = !cur_found || cand_outranks;
    end
  end

  // State registers; ICW1 reinitialises the block exactly like RESET.
  always_ff @(posedge CLK) begin
    if (RESET || bus.ICW1_RECEIVED) begin
      irr_q          <= '0;
      isr_q          <= '0;
      hist_q         <= '1;
      int_q          <= 1'b0;
      vector_level_q <= 3'd0;
      vector_valid_q <= 1'b0;
      lp_q           <= 3'd7;
      state_q        <= ST_IDLE;
      win_q          <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      hist_q         <= hist_d;
      int_q          <= int_d;
      vector_level_q <= vector_level_d;
      vector_valid_q <= vector_valid_d;
      lp_q           <= lp_d;
      state_q        <= state_d;
      win_q          <= win_d;
      spurious_q     <= spurious_d;
    end
  end

  assign bus.INT          = int_q;
  assign bus.IRR          = irr_q;
  assign bus.ISR          = isr_q;
  assign bus.VECTOR_LEVEL = vector_level_q;
  assign bus.VECTOR_VALID = vector_valid_q;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_interrupt_priority_arbiter
//
// Drives the arbiter through directed scenarios and a randomized phase.
// A behavioural model tracks IRR/ISR/INT/priority per cycle and queues the
// expected vector on every second INTA; an independent monitor compares the
// DUT against the model on each falling edge.
// ---------------------------------------------------------------------------
module tb_interrupt_priority_arbiter;

  logic clk;
  logic rst;

  interrupt_priority_arbiter_if bus ();

  interrupt_priority_arbiter #(
    .NUM_IR         (8),
    .SPURIOUS_LEVEL (7)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit monEnable  = 0;

  // Reference model state
  logic [7:0] mIrr, mIsr, mHist;
  bit         mInt, mVValid, mSpur;
  int         mLp, mPhase, mWin, mVLevel;
  int         expQ[$];

  // Highest-priority set level of v, scanning lp+1, lp+2, ... modulo 8.
  function automatic int bestOf(logic [7:0] v, int lp);
    for (int k = 1; k <= 8; k++) begin
      int lvl;
      lvl = (lp + k) % 8;
      if (v[lvl]) return lvl;
    end
    return -1;
  endfunction

  // Position in the priority order, 0 = highest.
  function automatic int rankOf(int lvl, int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT samples.
  task automatic modelStep();
    int         cand, cur, clearedLvl, nLp, nPhase;
    bit         eoiHit, nInt;
    logic [7:0] nIrr, nIsr;
    if (rst || bus.ICW1_RECEIVED) begin
      mIrr = 8'h00; mIsr = 8'h00; mHist = 8'hFF; mInt = 0;
      mVLevel = 0; mVValid = 0; mLp = 7; mPhase = 0; mWin = 0; mSpur = 0;
      return;
    end
    cand = bestOf(mIrr & ~bus.IMR, mLp);
    cur  = bestOf(mIsr, mLp);
    nInt = 0;
    if (mPhase == 0 && !bus.INTA && cand >= 0)
      nInt = (cur < 0) || (rankOf(cand, mLp) < rankOf(cur, mLp));
    nIrr = bus.LEVEL_MODE ? bus.IR : (mIrr | (bus.IR & ~mHist));
    nIsr = mIsr;
    nLp = mLp;
    nPhase = mPhase;
    mVValid = 0;
    if (mPhase == 1 && bus.INTA) begin
      expQ.push_back(mWin);
      mVValid = 1;
      mVLevel = mWin;
      if (bus.AUTO_EOI && !mSpur) begin
        nIsr[mWin] = 1'b0;
        if (bus.ROTATE_ON_AEOI) nLp = mWin;
      end
      nPhase = 2;
    end else if (mPhase == 2) begin
      nPhase = 0;
    end
    eoiHit = 0;
    clearedLvl = 0;
    if (bus.SP_EOI) begin
      eoiHit = 1; clearedLvl = int'(bus.EOI_LEVEL);
    end else if (bus.NS_EOI && cur >= 0) begin
      eoiHit = 1; clearedLvl = cur;
    end
    if (eoiHit) begin
      nIsr[clearedLvl] = 1'b0;
      if (bus.ROTATE) nLp = clearedLvl;
    end
    if (bus.SET_PRIORITY) nLp = int'(bus.EOI_LEVEL);
    if (mPhase == 0 && bus.INTA) begin
      nPhase = 1;
      if (cand >= 0) begin
        mWin = cand; mSpur = 0;
        nIsr[cand] = 1'b1;
        nIrr[cand] = 1'b0;
      end else begin
        mWin = 7; mSpur = 1;
      end
    end
    mIrr = nIrr; mIsr = nIsr; mLp = nLp; mPhase = nPhase; mInt = nInt;
    mHist = bus.IR;
  endtask

  // One clock: model follows the edge, strobes drop after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    #1;
    rst = 0;
    bus.ICW1_RECEIVED = 0;
    bus.INTA = 0;
    bus.NS_EOI = 0;
    bus.SP_EOI = 0;
    bus.ROTATE = 0;
    bus.SET_PRIORITY = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic ackPair();
    bus.INTA = 1; applyStimulus();
    bus.INTA = 1; applyStimulus();
  endtask

  // Reset, then one idle cycle with IR low so new edges can be seen.
  task automatic resetBlock();
    bus.IR = 8'h00;
    rst = 1; applyStimulus();
    applyStimulus();
  endtask

  // Monitor: per-cycle comparison plus scoreboard pop on each vector pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (monEnable) begin
        checkOutput("IRR", bus.IRR, mIrr);
        checkOutput("ISR", bus.ISR, mIsr);
        checkOutput("INT", {7'b0, bus.INT}, {7'b0, mInt});
        checkOutput("VECTOR_VALID", {7'b0, bus.VECTOR_VALID}, {7'b0, mVValid});
        checkOutput("VECTOR_LEVEL_HELD", {5'b0, bus.VECTOR_LEVEL}, 8'(mVLevel));
        if (bus.VECTOR_VALID) begin
          if (expQ.size() == 0) begin
            checkOutput("VECTOR_UNEXPECTED", 8'd1, 8'd0);
          end else begin
            int e;
            e = expQ.pop_front();
            checkOutput("VECTOR_SB", {5'b0, bus.VECTOR_LEVEL}, 8'(e));
          end
        end else if (expQ.size() != 0) begin
          void'(expQ.pop_front());
          checkOutput("VECTOR_MISSING", 8'd0, 8'd1);
        end
      end
    end
  end

  initial begin
    rst = 1;
    bus.ICW1_RECEIVED = 0; bus.IR = 8'h01; bus.IMR = 8'h00;
    bus.LEVEL_MODE = 0; bus.AUTO_EOI = 0; bus.ROTATE_ON_AEOI = 0;
    bus.INTA = 0; bus.NS_EOI = 0; bus.SP_EOI = 0; bus.ROTATE = 0;
    bus.SET_PRIORITY = 0; bus.EOI_LEVEL = 3'd0;

    // Reset with IR0 held high: no capture until it drops and rises.
    rst = 1; applyStimulus();
    monEnable = 1;
    checkOutput("RST_IRR", bus.IRR, 8'h00);
    checkOutput("RST_INT", {7'b0, bus.INT}, 8'h00);
    checkOutput("RST_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'h00);
    ticks(2);
    checkOutput("HELD_IRR", bus.IRR, 8'h00);
    bus.IR = 8'h00; applyStimulus();
    bus.IR = 8'h01; applyStimulus();
    checkOutput("EDGE_IRR", bus.IRR, 8'h01);
    applyStimulus();
    checkOutput("EDGE_INT", {7'b0, bus.INT}, 8'h01);

    // Two requests, IR2 wins under default priority.
    resetBlock();
    bus.IR = 8'h24; ticks(2);
    checkOutput("T2_INT", {7'b0, bus.INT}, 8'h01);
    ackPair();
    checkOutput("T2_ISR", bus.ISR, 8'h04);
    checkOutput("T2_IRR", bus.IRR, 8'h20);
    checkOutput("T2_VVALID", {7'b0, bus.VECTOR_VALID}, 8'h01);
    checkOutput("T2_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd2);
    ticks(2);
    checkOutput("T2_INT_NESTED", {7'b0, bus.INT}, 8'h00);
    bus.NS_EOI = 1; applyStimulus();
    applyStimulus();
    checkOutput("T2_INT_AFTER_EOI", {7'b0, bus.INT}, 8'h01);

    // Fully nested: lower-priority IR5 blocked, higher IR1 interrupts.
    resetBlock();
    bus.IR = 8'h08; ticks(2); ackPair(); applyStimulus();
    bus.IR = 8'h28; ticks(3);
    checkOutput("T3_INT_BLOCKED", {7'b0, bus.INT}, 8'h00);
    bus.IR = 8'h2A; ticks(2);
    checkOutput("T3_INT_NEST", {7'b0, bus.INT}, 8'h01);
    ackPair();
    checkOutput("T3_ISR", bus.ISR, 8'h0A);
    checkOutput("T3_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd1);

    // Rotating NS_EOI moves the lowest priority to 4, so IR5 beats IR0.
    resetBlock();
    bus.IR = 8'h10; ticks(2); ackPair(); applyStimulus();
    bus.NS_EOI = 1; bus.ROTATE = 1; applyStimulus();
    checkOutput("T4_ISR", bus.ISR, 8'h00);
    bus.IR = 8'h31; ticks(2); ackPair();
    checkOutput("T4_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd5);

    // Spurious acknowledge: request masked before INTA.
    resetBlock();
    bus.IR = 8'h01; applyStimulus();
    bus.IR = 8'h00; bus.IMR = 8'hFF; applyStimulus();
    ackPair();
    checkOutput("T5_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd7);
    checkOutput("T5_ISR", bus.ISR, 8'h00);
    checkOutput("T5_IRR", bus.IRR, 8'h01);
    bus.IMR = 8'h00;

    // Automatic EOI with rotation, then reset in the middle of ACK1.
    resetBlock();
    bus.AUTO_EOI = 1; bus.ROTATE_ON_AEOI = 1;
    bus.IR = 8'h40; ticks(2); ackPair();
    checkOutput("T6_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd6);
    checkOutput("T6_ISR", bus.ISR, 8'h00);
    bus.IR = 8'h81; ticks(2); ackPair();
    checkOutput("T6_ROT_VLEVEL", {5'b0, bus.VECTOR_LEVEL}, 8'd7);
    applyStimulus();
    bus.INTA = 1; applyStimulus();
    checkOutput("T6_ACK1_ISR", bus.ISR, 8'h01);
    rst = 1; applyStimulus();
    checkOutput("T6_RST_ISR", bus.ISR, 8'h00);
    checkOutput("T6_RST_IRR", bus.IRR, 8'h00);
    bus.IR = 8'h00; applyStimulus();
    bus.IR = 8'h81; ticks(2); ackPair();
    checkOutput("T6_RST_LP", {5'b0, bus.VECTOR_LEVEL}, 8'd0);
    bus.AUTO_EOI = 0; bus.ROTATE_ON_AEOI = 0;

    // Randomized traffic checked against the model by the monitor.
    for (int seg = 0; seg < 6; seg++) begin
      bus.LEVEL_MODE     = 1'($urandom_range(0, 1));
      bus.AUTO_EOI       = 1'($urandom_range(0, 1));
      bus.ROTATE_ON_AEOI = 1'($urandom_range(0, 1));
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(0, 9) < 3) bus.IR = 8'($urandom);
        if ($urandom_range(0, 19) == 0)
          bus.IMR = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        bus.INTA   = ($urandom_range(0, 3) == 0);
        bus.NS_EOI = ($urandom_range(0, 7) == 0);
        bus.SP_EOI = ($urandom_range(0, 11) == 0);
        bus.ROTATE = ($urandom_range(0, 2) == 0);
        bus.SET_PRIORITY = ($urandom_range(0, 19) == 0);
        bus.EOI_LEVEL = 3'($urandom_range(0, 7));
        bus.ICW1_RECEIVED = ($urandom_range(0, 149) == 0);
        applyStimulus();
      end
    end
    ticks(4);
    checkOutput("SB_DRAINED", 8'(expQ.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
